gen3_packet_assembler: RTL and testbench

Downstream consumer of the per-byte Gen3 framing classifier chain. Each cycle it takes up to LANES classified bytes, with their 6-bit type codes, and captures TLP and DLLP payload bytes into a two-bank ping-pong packet buffer. Good packets are committed and replayed as a byte stream with a valid/ready handshake and sop/eop markers. EDB-nullified, malformed or overflowing packets are discarded.

---
 rtl/gen3_pkt_pkg.sv | 25 ++
 rtl/gen3_pkt_bank.sv | 31 +++
 rtl/gen3_packet_assembler.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_gen3_packet_assembler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen3_pkt_pkg.sv
// Shared Gen3 framing definitions: lane type codes, capture FSM states
// and a lane-slice helper used by the classifier chain and the assembler.
package gen3_pkt_pkg;

    localparam logic [5:0] TC_DATA      = 6'b100000;
    localparam logic [5:0] TC_TLPSTART  = 6'b010000;
    localparam logic [5:0] TC_TLPEND    = 6'b001000;
    localparam logic [5:0] TC_DLLPEND   = 6'b000100;
    localparam logic [5:0] TC_DLLPSTART = 6'b000010;
    localparam logic [5:0] TC_TLPEDB    = 6'b000001;
    localparam logic [5:0] TC_NOT_VALID = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2,
        ST_DISC = 2'd3
    } cap_state_e;

    // Low bit index of lane 'lane' in a vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/gen3_pkt_bank.sv
// One packet buffer bank: LANES independent byte write ports, async 1-byte read.
// Ports: clk, we/waddr/wdata (per-lane write), raddr -> rdata.
module gen3_pkt_bank
    import gen3_pkt_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int BUF_BYTES = 512,
    parameter int AW        = $clog2(BUF_BYTES)
) (
    input  logic                  clk,
    input  logic [LANES-1:0]      we,
    input  logic [LANES*AW-1:0]   waddr,
    input  logic [8*LANES-1:0]    wdata,
    input  logic [AW-1:0]         raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [BUF_BYTES];

    // Lanes of one cycle always target distinct addresses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[waddr[lane_lo(i, AW) +: AW]] <= wdata[lane_lo(i, 8) +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gen3_packet_assembler.sv
// Gen3 packet assembler: captures classified TLP/DLLP bytes into a ping-pong
// buffer and replays committed packets as a valid/ready byte stream.
// Ports: clk, rst (sync, active-low), in_valid/data_in/type_in (LANES lanes),
// out_data/out_valid/out_ready/out_sop/out_eop/out_tlp, err_pulse, drop_pulse.
// Build option GEN3_PKT_STATS_EN adds stat_tlp/stat_dllp/stat_null/stat_drop.
module gen3_packet_assembler #(
    parameter int LANES     = 4,
    parameter int BUF_BYTES = 512,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [8*LANES-1:0] data_in,
    input  logic [6*LANES-1:0] type_in,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_tlp,
    output logic               err_pulse,
    output logic               drop_pulse
`ifdef GEN3_PKT_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_tlp,
    output logic [CNT_W-1:0]   stat_dllp,
    output logic [CNT_W-1:0]   stat_null,
    output logic [CNT_W-1:0]   stat_drop
`endif
);
    import gen3_pkt_pkg::*;

    localparam int AW = $clog2(BUF_BYTES);
    localparam int CW = AW + 1;

    if (CNT_W < 1 || (1 << AW) != BUF_BYTES) begin : g_param_chk
        $error("bad CNT_W or BUF_BYTES");
    end

    cap_state_e state_q, state_d;
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic ovf_q, ovf_d;
    logic [1:0] full_q, full_c, full_d, clr;
    logic [1:0][CW-1:0] len_q, len_d;
    logic [1:0] tlp_q, tlp_d;
    logic err_q, err_d, drop_q, drop_d;

    logic [LANES-1:0] we0, we1;
    logic [LANES*AW-1:0] waddr;
    logic [7:0] rdata0, rdata1, rd_byte;
    logic [CW-1:0] rd_len;
    logic fire, last;

    logic [5:0] tc;
    logic is_open, kill, nul, cmt, opn, opn_tlp, opn_full;

`ifdef GEN3_PKT_STATS_EN
    logic [2:0] n_tlp, n_dllp, n_null, n_drop;
    logic [CNT_W-1:0] st_tlp_q, st_tlp_d, st_dllp_q, st_dllp_d;
    logic [CNT_W-1:0] st_null_q, st_null_d, st_drop_q, st_drop_d;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [2:0]       b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
`endif

    gen3_pkt_bank #(.LANES(LANES), .BUF_BYTES(BUF_BYTES)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (rd_idx_q[AW-1:0]),
        .rdata (rdata0)
    );

    gen3_pkt_bank #(.LANES(LANES), .BUF_BYTES(BUF_BYTES)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (rd_idx_q[AW-1:0]),
        .rdata (rdata1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_idx_q  <= '0;
            ovf_q     <= 1'b0;
            full_q    <= '0;
            len_q     <= '0;
            tlp_q     <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            len_q     <= len_d;
            tlp_q     <= tlp_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    // Lanes are walked in order; every *_d acts as the running value.
    always_comb begin : cap_next
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        ovf_d     = ovf_q;
        full_c    = full_q;
        len_d     = len_q;
        tlp_d     = tlp_q;
        err_d     = 1'b0;
        drop_d    = 1'b0;
        we0       = '0;
        we1       = '0;
        waddr     = '0;
        tc        = TC_NOT_VALID;
        is_open   = 1'b0;
        kill      = 1'b0;
        nul       = 1'b0;
        cmt       = 1'b0;
        opn       = 1'b0;
        opn_tlp   = 1'b0;
        opn_full  = 1'b0;
`ifdef GEN3_PKT_STATS_EN
        n_tlp  = '0;
        n_dllp = '0;
        n_null = '0;
        n_drop = '0;
`endif
        if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                tc       = type_in[lane_lo(i, 6) +: 6];
                is_open  = (state_d == ST_TLP) || (state_d == ST_DLLP);
                kill     = 1'b0;
                nul      = 1'b0;
                cmt      = 1'b0;
                opn      = 1'b0;
                opn_tlp  = (tc == TC_TLPSTART);
                opn_full = 1'b0;
                unique case (1'b1)
                    (tc == TC_NOT_VALID): ;
                    (tc == TC_DATA): begin
                        if (is_open) begin
                            if (wr_cnt_d == CW'(BUF_BYTES)) begin
                                ovf_d = 1'b1;
                            end else begin
                                if (wr_bank_d) we1[i] = 1'b1;
                                else           we0[i] = 1'b1;
                                waddr[lane_lo(i, AW) +: AW] = wr_cnt_d[AW-1:0];
                                wr_cnt_d = wr_cnt_d + CW'(1);
                            end
                        end else if (state_d == ST_IDLE) begin
                            err_d = 1'b1;
                        end
                    end
                    (tc == TC_TLPSTART), (tc == TC_DLLPSTART): begin
                        kill  = is_open;
                        err_d = err_d | is_open;
                        opn   = 1'b1;
                    end
                    (tc == TC_TLPEND), (tc == TC_DLLPEND),
                    (tc == TC_TLPEDB): begin
                        if (state_d == ST_IDLE) begin
                            err_d = 1'b1;
                        end else begin
                            if (state_d == ST_TLP && tc == TC_TLPEDB) begin
                                nul = 1'b1;
                            end else if ((state_d == ST_TLP && tc == TC_TLPEND) ||
                                         (state_d == ST_DLLP && tc == TC_DLLPEND)) begin
                                if (!ovf_d && wr_cnt_d != '0) begin
                                    cmt = 1'b1;
                                end else begin
                                    kill  = 1'b1;
                                    err_d = err_d | (wr_cnt_d == '0);
                                end
                            end else if (is_open) begin
                                kill  = 1'b1;
                                err_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end
                    end
                    default: err_d = 1'b1;
                endcase

                if (cmt) begin
                    full_c[wr_bank_d] = 1'b1;
                    len_d[wr_bank_d]  = wr_cnt_d;
                    tlp_d[wr_bank_d]  = (tc == TC_TLPEND);
                    wr_bank_d         = ~wr_bank_d;
                end

                if (opn) begin
                    wr_cnt_d = '0;
                    ovf_d    = 1'b0;
                    opn_full = full_c[wr_bank_d];
                    if (opn_full)     state_d = ST_DISC;
                    else if (opn_tlp) state_d = ST_TLP;
                    else              state_d = ST_DLLP;
                end

                if (kill || nul || opn_full) drop_d = 1'b1;
`ifdef GEN3_PKT_STATS_EN
                n_drop = n_drop + 3'(kill) + 3'(opn_full);
                n_null = n_null + 3'(nul);
                n_tlp  = n_tlp + 3'(cmt && tc == TC_TLPEND);
                n_dllp = n_dllp + 3'(cmt && tc == TC_DLLPEND);
`endif
            end
        end
    end

    always_comb begin : rd_out
        rd_len    = len_q[rd_bank_q];
        rd_byte   = rd_bank_q ? rdata1 : rdata0;
        out_valid = full_q[rd_bank_q];
        out_sop   = out_valid && (rd_idx_q == '0);
        out_eop   = out_valid && (rd_idx_q == rd_len - CW'(1));
        out_tlp   = out_valid && tlp_q[rd_bank_q];
        out_data  = out_valid ? rd_byte : 8'h00;
        fire      = out_valid && out_ready;
        last      = fire && out_eop;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        clr       = '0;
        if (last) begin
            rd_idx_d       = '0;
            rd_bank_d      = ~rd_bank_q;
            clr[rd_bank_q] = 1'b1;
        end else if (fire) begin
            rd_idx_d = rd_idx_q + CW'(1);
        end
        // A commit never lands on the bank being released.
        full_d = full_c & ~clr;
    end

    assign err_pulse  = err_q;
    assign drop_pulse = drop_q;

`ifdef GEN3_PKT_STATS_EN
    always_comb begin : stat_next
        st_tlp_d  = sat_add(st_tlp_q, n_tlp);
        st_dllp_d = sat_add(st_dllp_q, n_dllp);
        st_null_d = sat_add(st_null_q, n_null);
        st_drop_d = sat_add(st_drop_q, n_drop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_tlp_q  <= '0;
            st_dllp_q <= '0;
            st_null_q <= '0;
            st_drop_q <= '0;
        end else begin
            st_tlp_q  <= st_tlp_d;
            st_dllp_q <= st_dllp_d;
            st_null_q <= st_null_d;
            st_drop_q <= st_drop_d;
        end
    end

    assign stat_tlp  = st_tlp_q;
    assign stat_dllp = st_dllp_q;
    assign stat_null = st_null_q;
    assign stat_drop = st_drop_q;
`endif

endmodule

// File: tb/tb_gen3_packet_assembler.sv
// Directed bench for gen3_packet_assembler: hand-built lane vectors,
// output bytes captured on handshakes and compared to expected packets.
module tb_gen3_packet_assembler;

    localparam logic [5:0] T_DATA = 6'b100000;
    localparam logic [5:0] T_TS   = 6'b010000;
    localparam logic [5:0] T_TE   = 6'b001000;
    localparam logic [5:0] T_DE   = 6'b000100;
    localparam logic [5:0] T_DS   = 6'b000010;
    localparam logic [5:0] T_EDB  = 6'b000001;
    localparam logic [5:0] T_NV   = 6'b000000;
    localparam int BUF = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [31:0] data_in = '0;
    logic [23:0] type_in = '0;
    logic [7:0] out_data;
    logic out_valid, out_sop, out_eop, out_tlp, err_pulse, drop_pulse;
`ifdef GEN3_PKT_STATS_EN
    logic [15:0] stat_tlp, stat_dllp, stat_null, stat_drop;
`endif

    gen3_packet_assembler #(.LANES(4), .BUF_BYTES(BUF), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .type_in    (type_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_tlp    (out_tlp),
        .err_pulse  (err_pulse),
        .drop_pulse (drop_pulse)
`ifdef GEN3_PKT_STATS_EN
        ,
        .stat_tlp   (stat_tlp),
        .stat_dllp  (stat_dllp),
        .stat_null  (stat_null),
        .stat_drop  (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] q[$];
    int qc[$];
    int n_errp = 0;
    int n_dropp = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                q.push_back({out_tlp, out_sop, out_eop, out_data});
                qc.push_back(cyc);
            end
            if (err_pulse) n_errp++;
            if (drop_pulse) n_dropp++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ent(input logic tlp, input logic sop,
                                        input logic eop, input logic [7:0] d);
        return {tlp, sop, eop, d};
    endfunction

    task automatic chk_q(input string tag, input int k, input logic [10:0] e);
        if (k < q.size()) chk(tag, 32'(q[k]), 32'(e));
    endtask

    task automatic drive(input logic [31:0] d, input logic [23:0] t);
        in_valid = 1'b1;
        data_in  = d;
        type_in  = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = '0;
        type_in  = '0;
    endtask

    task automatic b1(input logic [5:0] t, input logic [7:0] d);
        drive({24'h0, d}, {18'h0, t});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clrmon();
        q.delete();
        qc.delete();
        n_errp = 0;
        n_dropp = 0;
    endtask

    task automatic chk_pulses(input string tag, input int e, input int d);
        chk({tag, "_err"}, 32'(n_errp), 32'(e));
        chk({tag, "_drop"}, 32'(n_dropp), 32'(d));
    endtask

    // TLP with nbytes data bytes (value = index mod 256), packed 4 lanes/cycle.
    task automatic big_tlp(input int nbytes);
        logic [31:0] d;
        logic [23:0] t;
        int l;
        d = '0;
        t = '0;
        t[5:0] = T_TS;
        l = 1;
        for (int n = 0; n < nbytes; n++) begin
            d[l*8 +: 8] = n[7:0];
            t[l*6 +: 6] = T_DATA;
            l++;
            if (l == 4) begin
                drive(d, t);
                d = '0;
                t = '0;
                l = 0;
            end
        end
        if (l != 0) drive(d, t);
        b1(T_TE, 8'h00);
    endtask

    initial begin
        int bad;
        logic [7:0] bv;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_sop", 32'(out_sop), 0);
        chk("rst_eop", 32'(out_eop), 0);
        chk("rst_tlp", 32'(out_tlp), 0);
        chk("rst_pulses", 32'({err_pulse, drop_pulse}), 0);
        rst = 1'b1;
        idle(2);

        clrmon();
        b1(T_TS, 8'h00);
        for (int k = 1; k <= 8; k++) b1(T_DATA, 8'(k));
        b1(T_TE, 8'h00);
        idle(15);
        chk("tlp1_len", 32'(q.size()), 8);
        for (int k = 0; k < 8; k++)
            chk_q("tlp1_byte", k, ent(1'b1, k == 0, k == 7, 8'(k + 1)));
        chk_pulses("tlp1", 0, 0);

        clrmon();
        drive(32'hCCBBAA00, {T_DATA, T_DATA, T_DATA, T_DS});
        in_valid = 1'b1;
        data_in  = 32'h00FFEEDD;
        type_in  = {T_DE, T_DATA, T_DATA, T_DATA};
        @(negedge clk);
        chk("dllp_pre_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        type_in  = '0;
        @(negedge clk);
        chk("dllp_lat", 32'({out_valid, out_sop, out_data}), 32'h3AA);
        idle(10);
        chk("dllp_len", 32'(q.size()), 6);
        for (int k = 0; k < 6; k++) begin
            bv = 8'hAA + 8'(k * 17);
            chk_q("dllp_byte", k, ent(1'b0, k == 0, k == 5, bv));
        end
        chk_pulses("dllp", 0, 0);

        clrmon();
        b1(T_TS, 8'h00);
        for (int k = 0; k < 4; k++) b1(T_DATA, 8'h40);
        b1(T_EDB, 8'h00);
        idle(5);
        chk("edb_len", 32'(q.size()), 0);
        chk_pulses("edb", 0, 1);
`ifdef GEN3_PKT_STATS_EN
        chk("stat_null", 32'(stat_null), 1);
        chk("stat_tlp", 32'(stat_tlp), 1);
        chk("stat_dllp", 32'(stat_dllp), 1);
        chk("stat_drop", 32'(stat_drop), 0);
`endif

        clrmon();
        b1(T_DS, 8'h00);
        b1(T_DATA, 8'h11);
        drive(32'h33000022, {T_DATA, T_TS, T_DE, T_DATA});
        b1(T_DATA, 8'h44);
        b1(T_TE, 8'h00);
        idle(10);
        chk("pair_len", 32'(q.size()), 4);
        chk_q("pair_b0", 0, ent(1'b0, 1'b1, 1'b0, 8'h11));
        chk_q("pair_b1", 1, ent(1'b0, 1'b0, 1'b1, 8'h22));
        chk_q("pair_b2", 2, ent(1'b1, 1'b1, 1'b0, 8'h33));
        chk_q("pair_b3", 3, ent(1'b1, 1'b0, 1'b1, 8'h44));
        if (qc.size() >= 3) chk("pair_gap", 32'(qc[2] - qc[1]), 1);
        chk_pulses("pair", 0, 0);

        clrmon();
        out_ready = 1'b0;
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'hA1);
        b1(T_DATA, 8'hA2);
        b1(T_TE, 8'h00);
        b1(T_DS, 8'h00);
        b1(T_DATA, 8'hB1);
        b1(T_DE, 8'h00);
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'hC1);
        b1(T_TE, 8'h00);
        idle(3);
        chk_pulses("full", 0, 1);
        chk("full_hold", 32'({out_valid, out_sop, out_eop, out_tlp, out_data}),
            32'hDA1);
        chk("full_none", 32'(q.size()), 0);
        out_ready = 1'b1;
        idle(10);
        chk("full_len", 32'(q.size()), 3);
        chk_q("full_b0", 0, ent(1'b1, 1'b1, 1'b0, 8'hA1));
        chk_q("full_b1", 1, ent(1'b1, 1'b0, 1'b1, 8'hA2));
        chk_q("full_b2", 2, ent(1'b0, 1'b1, 1'b1, 8'hB1));

        clrmon();
        b1(T_DS, 8'h00);
        b1(T_DE, 8'h00);
        idle(3);
        chk_pulses("zlen", 1, 1);
        clrmon();
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'h01);
        b1(T_DE, 8'h00);
        b1(6'b110000, 8'h00);
        idle(3);
        chk_pulses("mism", 2, 1);
        chk("mism_len", 32'(q.size()), 0);

        clrmon();
        big_tlp(BUF);
        idle(BUF + 20);
        chk("max_len", 32'(q.size()), BUF);
        chk_q("max_first", 0, ent(1'b1, 1'b1, 1'b0, 8'h00));
        chk_q("max_last", BUF - 1, ent(1'b1, 1'b0, 1'b1, 8'hFF));
        bad = 0;
        for (int k = 1; k < BUF - 1 && k < q.size(); k++)
            if (q[k] !== ent(1'b1, 1'b0, 1'b0, 8'(k))) bad++;
        chk("max_body", 32'(bad), 0);
        chk_pulses("max", 0, 0);

        clrmon();
        big_tlp(BUF + 1);
        idle(10);
        chk("ovf_len", 32'(q.size()), 0);
        chk_pulses("ovf", 0, 1);

        clrmon();
        out_ready = 1'b0;
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'h99);
        b1(T_TE, 8'h00);
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'h55);
        @(negedge clk);
        chk("mid_pre", 32'(out_valid), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst",
            32'({out_valid, out_sop, out_eop, out_tlp, err_pulse,
                 drop_pulse, out_data}), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        clrmon();
        b1(T_TS, 8'h00);
        b1(T_DATA, 8'h5A);
        b1(T_DATA, 8'h5B);
        b1(T_TE, 8'h00);
        idle(8);
        chk("post_len", 32'(q.size()), 2);
        chk_q("post_b0", 0, ent(1'b1, 1'b1, 1'b0, 8'h5A));
        chk_q("post_b1", 1, ent(1'b1, 1'b0, 1'b1, 8'h5B));
        chk_pulses("post", 0, 0);
`ifdef GEN3_PKT_STATS_EN
        chk("post_stat",
            32'({stat_tlp[7:0], stat_dllp[7:0], stat_null[7:0],
                 stat_drop[7:0]}), 32'h01000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
